// File: rtl/operand_fetch.sv
`default_nettype none
// ============================================================================
// Module      : operand_fetch
// Description : General register file plus a four-state sequencer that latches
//               the A and B operands and presents them to the ALU.
// Revision    : 1.0 - initial release
// ============================================================================
module operand_fetch #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] rn,
    input  logic [ADDR_W-1:0] rm,
    input  logic [1:0]        shift,
    input  logic              asel,
    input  logic              bsel,
    input  logic [DATA_W-1:0] sximm5,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_num,
    input  logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              op_valid,
    output logic [DATA_W-1:0] val_A,
    output logic [DATA_W-1:0] val_B
);

    localparam int c_REGS = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RDA   = 2'd1,
        S_RDB   = 2'd2,
        S_VALID = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [DATA_W-1:0]   r_regs [c_REGS];
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic [ADDR_W-1:0]   r_rn;
    logic [ADDR_W-1:0]   r_rm;
    logic [1:0]          r_shift;
    logic                r_asel;
    logic                r_bsel;
    logic [DATA_W-1:0]   r_sximm5;
    logic                w_capture;

    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        busy         = 1'b1;
        op_valid     = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_next_state = S_RDA;
                    w_capture    = 1'b1;
                end
            end
            S_RDA:   w_next_state = S_RDB;
            S_RDB:   w_next_state = S_VALID;
            S_VALID: begin
                op_valid     = 1'b1;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Latches read the register file before this edge's write lands: no bypass.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            for (int i = 0; i < c_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_a      <= '0;
            r_b      <= '0;
            r_rn     <= '0;
            r_rm     <= '0;
            r_shift  <= '0;
            r_asel   <= 1'b0;
            r_bsel   <= 1'b0;
            r_sximm5 <= '0;
        end else begin
            r_state <= w_next_state;
            if (wr_en) begin
                r_regs[wr_num] <= wr_data;
            end
            if (w_capture) begin
                r_rn     <= rn;
                r_rm     <= rm;
                r_shift  <= shift;
                r_asel   <= asel;
                r_bsel   <= bsel;
                r_sximm5 <= sximm5;
            end
            if (r_state == S_RDA) begin
                r_a <= r_regs[r_rn];
            end
            if (r_state == S_RDB) begin
                r_b <= r_regs[r_rm];
            end
        end
    end

    always_comb begin
        val_A = r_asel ? '0 : r_a;
        val_B = r_b;
        if (r_bsel) begin
            val_B = r_sximm5;
        end else begin
            case (r_shift)
                2'b01:   val_B = {r_b[DATA_W-2:0], 1'b0};
                2'b10:   val_B = {1'b0, r_b[DATA_W-1:1]};
                2'b11:   val_B = {r_b[DATA_W-1], r_b[DATA_W-1:1]};
                default: val_B = r_b;
            endcase
        end
    end

endmodule
`default_nettype wire
